// File: rtl/clock_pkg.sv
// Shared definitions for the multi-mode time-of-day clock: FSM states,
// field limits, 7-segment patterns and the 0-59 binary-to-BCD helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;  // minutes and seconds share the limit

  // Active-high patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Repeated subtraction keeps this divider-free for the 0-59 range.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = '0;
    rem  = v;
    for (int unsigned i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, 4'(rem)};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to 7-segment pattern, with blanking and selectable polarity.
module seg7_decoder
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] lit;

  always_comb begin
    lit = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    lit = SEG_0;
        4'd1:    lit = SEG_1;
        4'd2:    lit = SEG_2;
        4'd3:    lit = SEG_3;
        4'd4:    lit = SEG_4;
        4'd5:    lit = SEG_5;
        4'd6:    lit = SEG_6;
        4'd7:    lit = SEG_7;
        4'd8:    lit = SEG_8;
        4'd9:    lit = SEG_9;
        default: lit = SEG_BLANK;
      endcase
    end
    seg_o = SEG_ACTIVE_LOW ? ~lit : lit;
  end

endmodule

// File: rtl/multi_mode_clock.sv
// Time-of-day core with 12h/24h display, seconds prescaler, set-mode FSM
// and blinking of the field under edit, driving six 7-segment digits.
module multi_mode_clock
  import clock_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 50000000,
  parameter int unsigned BLINK_CYCLES   = 25000000,
  parameter bit          START_24H      = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_pulse,
  input  logic        up_pulse,
  input  logic        down_pulse,
  output logic [41:0] seg,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        mode_24h,
  output logic [1:0]  state
);

  localparam int unsigned PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam int unsigned BW = (BLINK_CYCLES > 0) ? $clog2(2 * BLINK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CYCLES_PER_SEC - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(2 * BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLK_HALF  = BW'(BLINK_CYCLES);

  state_e        state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          mode_q, mode_d;

  logic          up, dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      pre_q   <= '0;
      blink_q <= '0;
      mode_q  <= START_24H;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      blink_q <= blink_d;
      mode_q  <= mode_d;
    end
  end

  // set_pulse outranks up/down; opposing up and down cancel each other.
  assign up = up_pulse & ~down_pulse & ~set_pulse;
  assign dn = down_pulse & ~up_pulse & ~set_pulse;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    blink_d = blink_q;
    mode_d  = mode_q;
    if (state_q == RUN) begin
      blink_d = '0;
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (sec_q == MIN_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d  = '0;
            hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
      if (up) mode_d = ~mode_q;
      if (set_pulse) begin
        state_d = SET_HR;
        pre_d   = '0;
      end
    end else begin
      pre_d   = '0;
      blink_d = (blink_q == BLK_LAST) ? '0 : blink_q + 1'b1;
      if (up || dn) begin
        blink_d = '0;
        case (state_q)
          SET_HR:  hour_d = up ? ((hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1)
                               : ((hour_q == '0) ? HOUR_MAX : hour_q - 5'd1);
          SET_MIN: min_d  = up ? ((min_q == MIN_MAX) ? '0 : min_q + 6'd1)
                               : ((min_q == '0) ? MIN_MAX : min_q - 6'd1);
          default: sec_d  = up ? ((sec_q == MIN_MAX) ? '0 : sec_q + 6'd1)
                               : ((sec_q == '0) ? MIN_MAX : sec_q - 6'd1);
        endcase
      end
      if (set_pulse) begin
        blink_d = '0;
        case (state_q)
          SET_HR:  state_d = SET_MIN;
          SET_MIN: state_d = SET_SEC;
          default: state_d = RUN;
        endcase
      end
    end
  end

  logic [4:0] hour_disp;
  logic [7:0] hr_disp_bcd, hr_bcd, min_bcd, sec_bcd;
  logic       blink_off;
  logic [5:0] blank_dig;
  logic [3:0] dig [6];

  always_comb begin
    hour_disp = hour_q;
    if (!mode_q) begin
      if (hour_q == 5'd0)       hour_disp = 5'd12;
      else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
    end
  end

  assign hr_disp_bcd = bin2bcd({1'b0, hour_disp});
  assign hr_bcd      = bin2bcd({1'b0, hour_q});
  assign min_bcd     = bin2bcd(min_q);
  assign sec_bcd     = bin2bcd(sec_q);

  assign blink_off = (state_q != RUN) && (blink_q >= BLK_HALF);
  assign blank_dig = {{2{blink_off && (state_q == SET_HR)}},
                      {2{blink_off && (state_q == SET_MIN)}},
                      {2{blink_off && (state_q == SET_SEC)}}};

  assign dig[0] = sec_bcd[3:0];
  assign dig[1] = sec_bcd[7:4];
  assign dig[2] = min_bcd[3:0];
  assign dig[3] = min_bcd[7:4];
  assign dig[4] = hr_disp_bcd[3:0];
  assign dig[5] = hr_disp_bcd[7:4];

  for (genvar k = 0; k < 6; k++) begin : g_digit
    seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
      .bcd_i   (dig[k]),
      .blank_i (blank_dig[k]),
      .seg_o   (seg[7*k +: 7])
    );
  end

  assign time_bcd = {hr_bcd, min_bcd, sec_bcd};
  assign pm       = (hour_q >= 5'd12);
  assign mode_24h = mode_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multi_mode_clock.sv
// Self-checking bench for multi_mode_clock: vector table, directed corner
// sequences and randomized pulses against a seconds-of-day reference model.
module tb_multi_mode_clock;

  localparam int CPS = 4;
  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_pulse, up_pulse, down_pulse;
  logic [41:0] seg;
  logic [23:0] time_bcd;
  logic        pm, mode_24h;
  logic [1:0]  state;

  always #5 clk = ~clk;

  multi_mode_clock #(
    .CYCLES_PER_SEC (CPS),
    .BLINK_CYCLES   (BLK),
    .START_24H      (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .set_pulse  (set_pulse),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .seg        (seg),
    .time_bcd   (time_bcd),
    .pm         (pm),
    .mode_24h   (mode_24h),
    .state      (state)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: time as seconds since midnight.
  int m_t, m_state, m_pre, m_idle;
  bit m_mode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] digit_pat(input int v);
    logic [6:0] p;
    case (v)
      0: p = 7'b0111111; 1: p = 7'b0000110; 2: p = 7'b1011011; 3: p = 7'b1001111;
      4: p = 7'b1100110; 5: p = 7'b1101101; 6: p = 7'b1111101; 7: p = 7'b0000111;
      8: p = 7'b1111111; default: p = 7'b1101111;
    endcase
    return ~p;
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_state = 0; m_pre = 0; m_idle = 0; m_mode = 1'b1;
  endtask

  task automatic model_step(input bit s, input bit u, input bit d);
    bit uu, dd;
    int h, mi, se;
    uu = u && !d && !s;
    dd = d && !u && !s;
    if (m_state == 0) begin
      m_pre++;
      if (m_pre == CPS) begin
        m_pre = 0;
        m_t = (m_t + 1) % 86400;
      end
      if (uu) m_mode = !m_mode;
      m_idle = 0;
      if (s) begin m_state = 1; m_pre = 0; end
    end else begin
      m_pre = 0;
      m_idle++;
      if (uu || dd) begin
        h = m_t / 3600; mi = (m_t / 60) % 60; se = m_t % 60;
        if (m_state == 1) h  = (h + (uu ? 1 : 23)) % 24;
        if (m_state == 2) mi = (mi + (uu ? 1 : 59)) % 60;
        if (m_state == 3) se = (se + (uu ? 1 : 59)) % 60;
        m_t = h * 3600 + mi * 60 + se;
        m_idle = 0;
      end
      if (s) begin m_state = (m_state + 1) % 4; m_idle = 0; end
    end
  endtask

  task automatic full_check(input string tag);
    int h, mi, se, dh;
    bit blank_on;
    logic [41:0] exp_seg;
    int vals [6];
    h = m_t / 3600; mi = (m_t / 60) % 60; se = m_t % 60;
    dh = m_mode ? h : ((h % 12 == 0) ? 12 : h % 12);
    vals = '{se % 10, se / 10, mi % 10, mi / 10, dh % 10, dh / 10};
    blank_on = (m_state != 0) && ((m_idle % (2 * BLK)) >= BLK);
    for (int k = 0; k < 6; k++) begin
      if (blank_on && (m_state == 3 - k / 2)) exp_seg[7*k +: 7] = 7'h7F;
      else exp_seg[7*k +: 7] = digit_pat(vals[k]);
    end
    check({tag, "/time_bcd"}, 64'(time_bcd), 64'({bcd2(h), bcd2(mi), bcd2(se)}));
    check({tag, "/pm"}, 64'(pm), 64'(h >= 12));
    check({tag, "/mode"}, 64'(mode_24h), 64'(m_mode));
    check({tag, "/state"}, 64'(state), 64'(m_state));
    check({tag, "/seg"}, 64'(seg), 64'(exp_seg));
  endtask

  task automatic step(input bit s, input bit u, input bit d);
    set_pulse = s; up_pulse = u; down_pulse = d;
    @(posedge clk);
    model_step(s, u, d);
    #1;
    set_pulse = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0;
    full_check("step");
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    model_reset();
    full_check("reset");
    check("reset/state0", 64'(state), 64'd0);
    check("reset/time0", 64'(time_bcd), 64'd0);
    check("reset/mode", 64'(mode_24h), 64'd1);
    #2;
    reset = 1'b1;
  endtask

  task automatic set_time(input int h, input int mi, input int se);
    step(1, 0, 0);
    repeat ((h - m_t / 3600 + 24) % 24) step(0, 1, 0);
    step(1, 0, 0);
    repeat ((mi - (m_t / 60) % 60 + 60) % 60) step(0, 1, 0);
    step(1, 0, 0);
    repeat ((se - m_t % 60 + 60) % 60) step(0, 1, 0);
    step(1, 0, 0);
  endtask

  typedef struct {
    bit          s, u, d;
    logic [1:0]  exp_state;
    logic [23:0] exp_bcd;
    bit          exp_mode;
  } vec_t;

  vec_t vecs [22];
  bit   saw_pm_rise;
  bit   prev_pm;

  initial begin
    reset = 1'b0; set_pulse = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0;
    #12;
    model_reset();
    full_check("por");
    reset = 1'b1;

    // Reset then four cycles gives the first tick.
    repeat (4) step(0, 0, 0);
    check("first_tick", 64'(time_bcd), 64'h000001);

    // Vector table: set-mode walk, wraps, simultaneous pulses, RUN re-entry.
    apply_reset();
    vecs = '{
      '{1,0,0, 2'd1, 24'h000000, 1}, '{0,1,0, 2'd1, 24'h010000, 1},
      '{0,0,1, 2'd1, 24'h000000, 1}, '{0,0,1, 2'd1, 24'h230000, 1},
      '{0,0,1, 2'd1, 24'h220000, 1}, '{0,1,0, 2'd1, 24'h230000, 1},
      '{0,1,0, 2'd1, 24'h000000, 1}, '{0,1,1, 2'd1, 24'h000000, 1},
      '{1,0,0, 2'd2, 24'h000000, 1}, '{0,0,1, 2'd2, 24'h005900, 1},
      '{0,1,0, 2'd2, 24'h000000, 1}, '{0,1,0, 2'd2, 24'h000100, 1},
      '{1,1,0, 2'd3, 24'h000100, 1}, '{0,0,1, 2'd3, 24'h000159, 1},
      '{0,1,0, 2'd3, 24'h000100, 1}, '{0,1,0, 2'd3, 24'h000101, 1},
      '{1,0,0, 2'd0, 24'h000101, 1}, '{0,1,0, 2'd0, 24'h000101, 0},
      '{0,0,0, 2'd0, 24'h000101, 0}, '{0,0,0, 2'd0, 24'h000101, 0},
      '{0,0,0, 2'd0, 24'h000102, 0}, '{0,1,0, 2'd0, 24'h000102, 1}
    };
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].s, vecs[i].u, vecs[i].d);
      check($sformatf("vec%0d/state", i), 64'(state), 64'(vecs[i].exp_state));
      check($sformatf("vec%0d/bcd", i), 64'(time_bcd), 64'(vecs[i].exp_bcd));
      check($sformatf("vec%0d/mode", i), 64'(mode_24h), 64'(vecs[i].exp_mode));
    end

    // pm rises exactly at 12:00:00.
    set_time(11, 59, 58);
    saw_pm_rise = 1'b0;
    prev_pm = pm;
    repeat (12) begin
      step(0, 0, 0);
      if (pm && !prev_pm) begin
        saw_pm_rise = 1'b1;
        check("pm_rise_time", 64'(time_bcd), 64'h120000);
      end
      prev_pm = pm;
    end
    check("pm_rise_seen", 64'(saw_pm_rise), 64'd1);

    // Midnight rollover with carry through all fields.
    set_time(23, 59, 58);
    repeat (7) step(0, 0, 0);
    check("pre_wrap", 64'(time_bcd), 64'h235959);
    step(0, 0, 0);
    check("wrap", 64'(time_bcd), 64'h000000);
    check("wrap_pm", 64'(pm), 64'd0);

    // 12h display of 13:05 and of hour 0.
    set_time(13, 5, 0);
    step(0, 1, 0);
    check("12h_mode", 64'(mode_24h), 64'd0);
    check("12h_pm", 64'(pm), 64'd1);
    check("12h_hr13", 64'(seg[41:28]), 64'({7'h40, 7'h79}));
    set_time(0, 7, 0);
    check("12h_mode_held", 64'(mode_24h), 64'd0);
    check("12h_hr0", 64'(seg[41:28]), 64'({7'h79, 7'h24}));
    step(0, 1, 0);

    // Blink of minutes field, cleared by up; set wins over up.
    apply_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    check("blink_on7", 64'({seg[27:21] == 7'h7F, seg[20:14] == 7'h7F}), 64'd0);
    step(0, 0, 0);
    check("blink_off8", 64'({seg[27:21] == 7'h7F, seg[20:14] == 7'h7F}), 64'b11);
    check("blink_others", 64'({seg[41:35] == 7'h7F, seg[13:7] == 7'h7F}), 64'd0);
    step(0, 1, 0);
    check("blink_clear", 64'({seg[27:21] == 7'h7F, seg[20:14] == 7'h7F}), 64'd0);
    check("blink_min", 64'(time_bcd[15:8]), 64'h01);
    step(1, 1, 0);
    check("set_wins_state", 64'(state), 64'd3);
    check("set_wins_min", 64'(time_bcd[15:8]), 64'h01);

    // Reset during SET_SEC abandons the edit.
    step(0, 1, 0);
    apply_reset();
    step(0, 0, 0);

    // Randomized pulses against the reference model.
    set_time(11, 58, 30);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
